// File: rtl/gpu_host_command_sequencer_if.sv
// Host-side command/response handshake of the GPU host command sequencer.
// The host drives requests; the sequencer returns one response per operation.
interface gpu_host_command_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_address;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_address, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_address, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/gpu_host_command_sequencer.sv
// Turns host RAM read/write operations into three-step request/busy handshakes
// on the GPU command word, with per-phase timeout and core-state abort.
module gpu_host_command_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    gpu_host_command_sequencer_if.slave   host,
    input  logic                          core_reset_n_in,
    input  logic                          core_run_in,
    output logic [31:0]                   h2f_value,
    input  logic [31:0]                   f2h_value
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // {command[7:0], parameter[15:0]} for a given step of an operation
    function automatic logic [23:0] step_word(input logic [1:0]  op,
                                              input logic [1:0]  step,
                                              input logic [15:0] addr,
                                              input logic [31:0] wdata);
        logic [23:0] w;
        w = 24'h0;
        if (!op[1]) begin
            case (step)
                2'd0:    w = {8'd0, wdata[15:0]};
                2'd1:    w = {8'd1, wdata[31:16]};
                default: w = {(op[0] ? 8'd3 : 8'd2), addr};
            endcase
        end else begin
            case (step)
                2'd0:    w = {(op[0] ? 8'd5 : 8'd4), addr};
                2'd1:    w = {8'd9, 16'h0000};
                default: w = {8'd10, 16'h0000};
            endcase
        end
        return w;
    endfunction

    state_t        state_r;
    logic [1:0]    op_r;
    logic [15:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [1:0]    step_r;
    logic [CW-1:0] cnt_r;
    logic          err_r;
    logic [31:0]   rdata_r;
    logic          req_r;
    logic [23:0]   word_r;
    logic          rsp_valid_r;
    logic [31:0]   rsp_rdata_r;
    logic          rsp_error_r;

    logic          busy_s;
    logic          cmd_err_s;
    logic          cmd_ready_s;
    logic          abort_s;
    logic [31:0]   next_rdata_s;
    logic          unused_s;

    assign busy_s    = f2h_value[30];
    assign cmd_err_s = f2h_value[29];
    assign unused_s  = ^f2h_value[28:16];

    assign cmd_ready_s = (state_r == IDLE) && f2h_value[31] && !f2h_value[30]
                         && core_reset_n_in && !core_run_in;
    assign abort_s     = !core_reset_n_in || core_run_in || (cnt_r == CW'(TIMEOUT_CYCLES));

    assign host.cmd_ready = cmd_ready_s;
    assign host.rsp_valid = rsp_valid_r;
    assign host.rsp_rdata = rsp_rdata_r;
    assign host.rsp_error = rsp_error_r;

    // GPU reset/run levels pass straight through; the rest of the word is registered
    assign h2f_value = {core_reset_n_in, core_run_in, req_r, 5'b00000, word_r};

    // Read data as it would look if the current step completed this cycle
    always_comb begin
        next_rdata_s = rdata_r;
        if (op_r[1] && (step_r == 2'd1)) begin
            next_rdata_s[15:0] = f2h_value[15:0];
        end else if (op_r[1] && (step_r == 2'd2)) begin
            next_rdata_s[31:16] = f2h_value[15:0];
        end else begin
            next_rdata_s = rdata_r;
        end
    end

    // Operation sequencer FSM with registered command word and response
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            op_r        <= 2'd0;
            addr_r      <= 16'h0000;
            wdata_r     <= 32'h0000_0000;
            step_r      <= 2'd0;
            cnt_r       <= '0;
            err_r       <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            req_r       <= 1'b0;
            word_r      <= 24'h00_0000;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (host.cmd_valid && cmd_ready_s) begin
                        op_r    <= host.cmd_op;
                        addr_r  <= host.cmd_address;
                        wdata_r <= host.cmd_wdata;
                        step_r  <= 2'd0;
                        cnt_r   <= '0;
                        err_r   <= 1'b0;
                        rdata_r <= 32'h0000_0000;
                        req_r   <= 1'b1;
                        word_r  <= step_word(host.cmd_op, 2'd0, host.cmd_address, host.cmd_wdata);
                        state_r <= REQ;
                    end
                end
                REQ: begin
                    if (abort_s) begin
                        req_r       <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_error_r <= 1'b1;
                        rsp_rdata_r <= rdata_r;
                        state_r     <= DONE;
                    end else if (busy_s) begin
                        req_r   <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= REL;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                REL: begin
                    if (abort_s) begin
                        req_r       <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_error_r <= 1'b1;
                        rsp_rdata_r <= rdata_r;
                        state_r     <= DONE;
                    end else if (!busy_s) begin
                        err_r   <= err_r | cmd_err_s;
                        rdata_r <= next_rdata_s;
                        if (step_r == 2'd2) begin
                            rsp_valid_r <= 1'b1;
                            rsp_error_r <= err_r | cmd_err_s;
                            rsp_rdata_r <= next_rdata_s;
                            state_r     <= DONE;
                        end else begin
                            step_r  <= step_r + 2'd1;
                            cnt_r   <= '0;
                            req_r   <= 1'b1;
                            word_r  <= step_word(op_r, step_r + 2'd1, addr_r, wdata_r);
                            state_r <= REQ;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    req_r       <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_host_command_sequencer.sv
// Directed bench for gpu_host_command_sequencer: a small GPU responder model plus
// step and response scoreboards filled when each operation is issued.
module tb_gpu_host_command_sequencer;

    localparam int TO = 255;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        core_reset_n_in;
    logic        core_run_in;
    logic [31:0] h2f_value;
    logic [31:0] f2h_value;

    gpu_host_command_sequencer_if bus();

    gpu_host_command_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .host            (bus),
        .core_reset_n_in (core_reset_n_in),
        .core_run_in     (core_run_in),
        .h2f_value       (h2f_value),
        .f2h_value       (f2h_value)
    );

    always #5 clock = ~clock;

    // Responder: busy follows request one cycle late; returns fixed GET data
    logic        exited;
    logic        resp_en;
    logic        inject_err;
    logic        busy_m = 1'b0;
    logic        err_m = 1'b0;
    logic [15:0] data_m = 16'h0000;

    always @(posedge clock) begin
        busy_m <= resp_en & h2f_value[29];
        err_m  <= inject_err & (h2f_value[23:16] == 8'd3);
        if (h2f_value[23:16] == 8'd9)       data_m <= 16'h5678;
        else if (h2f_value[23:16] == 8'd10) data_m <= 16'h1234;
        else                                data_m <= data_m;
    end

    assign f2h_value = {exited, busy_m, err_m, 13'h0000, data_m};

    logic [23:0] step_q[$];
    logic [33:0] rsp_q[$];   // {check_rdata, error, rdata}
    int total = 0;
    int bad = 0;
    int rsp_cnt = 0;
    logic prev_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compares each new request step and each response pulse
    always @(negedge clock) begin
        if (reset_n) begin
            if (h2f_value[29] && !prev_req) begin
                chk("step_pending", 32'(step_q.size() != 0), 32'd1);
                if (step_q.size() != 0) begin
                    logic [23:0] es;
                    es = step_q.pop_front();
                    chk("step_word", {8'h00, h2f_value[23:0]}, {8'h00, es});
                end
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                chk("ready_with_rsp", 32'(bus.cmd_ready), 32'd0);
                chk("rsp_pending", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    logic [33:0] er;
                    er = rsp_q.pop_front();
                    chk("rsp_error", 32'(bus.rsp_error), 32'(er[32]));
                    if (er[33]) chk("rsp_rdata", bus.rsp_rdata, er[31:0]);
                end
            end
        end
        prev_req <= h2f_value[29];
    end

    task automatic push_write(input logic [1:0] op, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic err);
        step_q.push_back({8'd0, wdata[15:0]});
        step_q.push_back({8'd1, wdata[31:16]});
        step_q.push_back({(op[0] ? 8'd3 : 8'd2), addr});
        rsp_q.push_back({1'b1, err, 32'h0000_0000});
    endtask

    task automatic push_read(input logic [1:0] op, input logic [15:0] addr,
                             input logic [31:0] rdata);
        step_q.push_back({(op[0] ? 8'd5 : 8'd4), addr});
        step_q.push_back({8'd9, 16'h0000});
        step_q.push_back({8'd10, 16'h0000});
        rsp_q.push_back({1'b1, 1'b0, rdata});
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wdata);
        int c;
        c = 0;
        @(negedge clock);
        while (!bus.cmd_ready && c < 50) begin
            @(negedge clock);
            c++;
        end
        chk("issue_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_address = addr;
        bus.cmd_wdata   = wdata;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int maxc, output int cycles);
        int base;
        base = rsp_cnt;
        cycles = 0;
        while (rsp_cnt == base && cycles < maxc) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        chk("rsp_arrived", 32'(rsp_cnt != base), 32'd1);
    endtask

    task automatic wait_req(input logic lvl, input int maxc);
        int c;
        c = 0;
        while (h2f_value[29] !== lvl && c < maxc) begin
            @(negedge clock);
            c++;
        end
        chk("req_level", 32'(h2f_value[29]), 32'(lvl));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int base;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'd0;
        bus.cmd_address = 16'h0000;
        bus.cmd_wdata   = 32'h0000_0000;
        reset_n         = 1'b0;
        core_reset_n_in = 1'b1;
        core_run_in     = 1'b0;
        exited          = 1'b0;
        resp_en         = 1'b1;
        inject_err      = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_h2f_low",   {2'b00, h2f_value[29:0]}, 32'h0);
        chk("rst_h2f_high",  32'(h2f_value[31:30]), 32'd2);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_ready_not_exited", 32'(bus.cmd_ready), 32'd0);

        reset_n = 1'b1;
        exited  = 1'b1;
        @(negedge clock);
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);

        push_write(2'd1, 16'h0012, 32'hDEAD_BEEF, 1'b0);
        issue(2'd1, 16'h0012, 32'hDEAD_BEEF);
        wait_rsp(60, cyc);

        push_read(2'd2, 16'h0004, 32'h1234_5678);
        issue(2'd2, 16'h0004, 32'h0000_0000);
        wait_rsp(60, cyc);

        push_write(2'd0, 16'hFFFF, 32'h0000_0000, 1'b0);
        issue(2'd0, 16'hFFFF, 32'h0000_0000);
        wait_rsp(60, cyc);

        push_read(2'd3, 16'h00A5, 32'h1234_5678);
        issue(2'd3, 16'h00A5, 32'hFFFF_FFFF);
        wait_rsp(60, cyc);

        // cmd_error on the WRITE step: all steps still issued, sticky error reported
        inject_err = 1'b1;
        push_write(2'd1, 16'h0030, 32'h1111_2222, 1'b1);
        issue(2'd1, 16'h0030, 32'h1111_2222);
        wait_rsp(60, cyc);
        inject_err = 1'b0;
        chk("cmderr_all_steps", 32'(step_q.size()), 32'd0);

        // Responder never raises busy
        resp_en = 1'b0;
        step_q.push_back({8'd0, 16'h0005});
        rsp_q.push_back({1'b0, 1'b1, 32'h0});
        issue(2'd0, 16'h0001, 32'h0000_0005);
        wait_rsp(TO + 20, cyc);
        chk("timeout_not_early", 32'(cyc >= TO), 32'd1);
        chk("timeout_req_low", 32'(h2f_value[29]), 32'd0);
        @(negedge clock);
        chk("timeout_ready_back", 32'(bus.cmd_ready), 32'd1);
        resp_en = 1'b1;

        // Gating: not exited, run requested, core held in reset
        base = rsp_cnt;
        exited = 1'b0;
        #1;
        chk("gate_exited_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        repeat (4) @(negedge clock);
        chk("gate_exited_no_req", 32'(h2f_value[29]), 32'd0);
        exited      = 1'b1;
        core_run_in = 1'b1;
        #1;
        chk("gate_run_h2f30", 32'(h2f_value[30]), 32'd1);
        chk("gate_run_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (4) @(negedge clock);
        chk("gate_run_no_req", 32'(h2f_value[29]), 32'd0);
        core_run_in     = 1'b0;
        core_reset_n_in = 1'b0;
        #1;
        chk("gate_rst_h2f31", 32'(h2f_value[31]), 32'd0);
        chk("gate_rst_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (2) @(negedge clock);
        bus.cmd_valid   = 1'b0;
        core_reset_n_in = 1'b1;
        chk("gate_no_rsp", 32'(rsp_cnt), 32'(base));

        // core_run_in raised once GET_LOW has started
        step_q.push_back({8'd5, 16'h0007});
        step_q.push_back({8'd9, 16'h0000});
        rsp_q.push_back({1'b0, 1'b1, 32'h0});
        issue(2'd3, 16'h0007, 32'h0000_0000);
        wait_req(1'b0, 20);
        wait_req(1'b1, 20);
        core_run_in = 1'b1;
        wait_rsp(20, cyc);
        core_run_in = 1'b0;
        chk("abort_steps_used", 32'(step_q.size()), 32'd0);

        // Reset pulse while in REL abandons the operation silently
        step_q.push_back({8'd0, 16'h0001});
        issue(2'd1, 16'h0055, 32'hABCD_0001);
        wait_req(1'b0, 20);
        base = rsp_cnt;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("rel_rst_h2f_low", {2'b00, h2f_value[29:0]}, 32'h0);
        chk("rel_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("rel_rst_no_rsp", 32'(rsp_cnt), 32'(base));
        chk("rel_rst_idle_ready", 32'(bus.cmd_ready), 32'd1);

        push_read(2'd2, 16'h0100, 32'h1234_5678);
        issue(2'd2, 16'h0100, 32'h0000_0000);
        wait_rsp(60, cyc);

        chk("end_step_q_empty", 32'(step_q.size()), 32'd0);
        chk("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
